ex_mem_lane_stage: RTL and testbench

- Parametrised EX→MEM pipeline stage for an N-issue core; generalises the fixed main+aux EX/MEM register.
- Uses a valid/ready handshake with a 2-entry skid buffer, so upstream ready is registered instead of driven from a combinational global hold.
- Applies in-bundle kill (branch taken, serialising op, interrupt), post-serialise bundle cancel, flush, and a saturating killed-lane counter.

---
 rtl/ex_mem_lane_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_ex_mem_lane_stage.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_lane_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_lane_stage
//
// EX->MEM pipeline register for an N-issue core. A bundle of LANES
// instructions (lane 0 oldest) is captured through a valid/ready handshake
// into a main register that drives MEM. A one-entry skid register behind it
// lets in_ready come straight from a flop, so no combinational hold path runs
// back into EX.
//
// Lanes are killed when the bundle is captured:
//   - any lane younger than a live serialising op, taken branch/jump, or
//     lane 0 carrying an interrupt is killed;
//   - after an accepted bundle whose surviving lanes include a serialising
//     op, the whole next accepted bundle is killed (ser_block).
// A fully killed bundle is still delivered with out_valid=1 and
// out_lane_vld=0, so PC and interrupt bookkeeping downstream still sees it.
// kill_cnt counts killed live lanes and saturates at all-ones.
// flush empties both registers and clears ser_block. kill_cnt and
// out_payload are kept across a flush.
//
// Ports
//   clk           clock
//   rstn          synchronous active-low reset
//   flush         pipeline flush, highest priority
//   in_valid      bundle offered by EX
//   in_ready      stage can accept a bundle (registered)
//   in_lane_vld   per-lane live instruction
//   in_wreg_en    per-lane register-file write enable
//   in_serial     per-lane CSR write / ecall / mret
//   in_taken      per-lane taken branch or jump
//   in_irq        {external, mtime} interrupt, tagged on lane 0
//   in_payload    lane i at [i*PAYLOAD_W +: PAYLOAD_W]
//   out_valid     bundle held in the main register
//   out_ready     MEM accepts the bundle
//   out_lane_vld  surviving lanes
//   out_wreg_en   write enables of surviving lanes
//   out_irq       interrupt flags, zero unless lane 0 survived
//   out_payload   payload of every lane, killed lanes included
//   kill_cnt      saturating count of lanes killed in this stage
//
// Handshake: a bundle moves on a rising clk edge where valid and ready are
// both high. Upstream may not withdraw or change a bundle offered while ready
// is low. in_ready depends only on state, never on in_valid or out_ready in
// the same cycle.
// ---------------------------------------------------------------------------
module ex_mem_lane_stage #(
   parameter int LANES     = 2,
   parameter int PAYLOAD_W = 192,
   parameter int CNT_W     = 16
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [LANES-1:0]             in_lane_vld,
   input  logic [LANES-1:0]             in_wreg_en,
   input  logic [LANES-1:0]             in_serial,
   input  logic [LANES-1:0]             in_taken,
   input  logic [1:0]                   in_irq,
   input  logic [LANES*PAYLOAD_W-1:0]   in_payload,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [LANES-1:0]             out_lane_vld,
   output logic [LANES-1:0]             out_wreg_en,
   output logic [1:0]                   out_irq,
   output logic [LANES*PAYLOAD_W-1:0]   out_payload,
   output logic [CNT_W-1:0]             kill_cnt
);

   localparam int PW = LANES * PAYLOAD_W;

   // Main register (drives the outputs)
   logic                main_vld;
   logic [LANES-1:0]    main_lane_vld;
   logic [LANES-1:0]    main_wreg;
   logic [1:0]          main_irq;
   logic [PW-1:0]       main_payload;

   // Skid register (second bundle while MEM stalls)
   logic                skid_vld;
   logic [LANES-1:0]    skid_lane_vld;
   logic [LANES-1:0]    skid_wreg;
   logic [1:0]          skid_irq;
   logic [PW-1:0]       skid_payload;

   logic                ser_block;
   logic                ready_q;
   logic [CNT_W-1:0]    cnt_q;

   // Capture-side kill evaluation
   logic [LANES-1:0]    surv;
   logic [LANES-1:0]    cap_wreg;
   logic [1:0]          cap_irq;
   logic                ser_set;
   logic                older_kill;
   logic [CNT_W-1:0]    kill_num;
   logic [CNT_W:0]      cnt_sum;
   logic [CNT_W-1:0]    cnt_next;

   // Movement control
   logic                accept;
   logic                drain;
   logic                main_free;
   logic                load_main_in;
   logic                load_main_skid;
   logic                load_skid;
   logic                main_vld_next;
   logic                skid_vld_next;

   // -------------------------------------------------------------------------
   // Kill evaluation. older_kill accumulates "some older live lane ends the
   // bundle" while walking from lane 0 upward. The killing lane itself
   // survives; only the lanes after it are dropped.
   // -------------------------------------------------------------------------
   always_comb begin
      older_kill = 1'b0;
      surv       = '0;
      for (int i = 0; i < LANES; i++) begin
         surv[i] = in_lane_vld[i] && !ser_block && !older_kill;
         if (in_lane_vld[i] &&
             (in_serial[i] || in_taken[i] || ((i == 0) && (|in_irq)))) begin
            older_kill = 1'b1;
         end
      end
   end

   always_comb begin
      cap_wreg = in_wreg_en & surv;
      cap_irq  = surv[0] ? in_irq : 2'b00;
      // Under ser_block nothing survives, so this also clears ser_block on
      // the bundle that consumes it.
      ser_set  = |(surv & in_serial);
   end

   // Killed lanes are the live ones that did not survive.
   always_comb begin
      kill_num = '0;
      for (int i = 0; i < LANES; i++) begin
         kill_num = kill_num + CNT_W'(in_lane_vld[i] & ~surv[i]);
      end
      cnt_sum  = {1'b0, cnt_q} + {1'b0, kill_num};
      cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
   end

   // -------------------------------------------------------------------------
   // Movement. The skid entry is always older than a new input, so when main
   // frees up the skid entry moves first and a simultaneous input lands in
   // skid. ready_q mirrors !skid_vld, so an accept never meets a full skid.
   // -------------------------------------------------------------------------
   always_comb begin
      accept         = in_valid && ready_q;
      drain          = main_vld && out_ready;
      main_free      = !main_vld || drain;
      load_main_skid = main_free && skid_vld;
      load_main_in   = accept && main_free && !skid_vld;
      load_skid      = accept && !load_main_in;
      main_vld_next  = load_main_skid || load_main_in || (main_vld && !drain);
      skid_vld_next  = load_skid || (skid_vld && !load_main_skid);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         main_vld      <= 1'b0;
         main_lane_vld <= '0;
         main_wreg     <= '0;
         main_irq      <= 2'b00;
         main_payload  <= '0;
         skid_vld      <= 1'b0;
         skid_lane_vld <= '0;
         skid_wreg     <= '0;
         skid_irq      <= 2'b00;
         skid_payload  <= '0;
         ser_block     <= 1'b0;
         ready_q       <= 1'b1;
         cnt_q         <= '0;
      end else if (flush) begin
         // Drop everything in flight, including this cycle's input. The
         // payload bits are left as they were.
         main_vld      <= 1'b0;
         main_lane_vld <= '0;
         main_wreg     <= '0;
         main_irq      <= 2'b00;
         skid_vld      <= 1'b0;
         ser_block     <= 1'b0;
         ready_q       <= 1'b1;
      end else begin
         main_vld <= main_vld_next;
         skid_vld <= skid_vld_next;
         ready_q  <= !skid_vld_next;

         if (accept) begin
            ser_block <= ser_set;
            cnt_q     <= cnt_next;
         end

         if (load_main_skid) begin
            main_lane_vld <= skid_lane_vld;
            main_wreg     <= skid_wreg;
            main_irq      <= skid_irq;
            main_payload  <= skid_payload;
         end else if (load_main_in) begin
            main_lane_vld <= surv;
            main_wreg     <= cap_wreg;
            main_irq      <= cap_irq;
            main_payload  <= in_payload;
         end

         if (load_skid) begin
            skid_lane_vld <= surv;
            skid_wreg     <= cap_wreg;
            skid_irq      <= cap_irq;
            skid_payload  <= in_payload;
         end
      end
   end

   assign in_ready     = ready_q;
   assign out_valid    = main_vld;
   assign out_lane_vld = main_lane_vld;
   assign out_wreg_en  = main_wreg;
   assign out_irq      = main_irq;
   assign out_payload  = main_payload;
   assign kill_cnt     = cnt_q;

endmodule

// File: tb/tb_ex_mem_lane_stage.sv
// ---------------------------------------------------------------------------
// Bench for ex_mem_lane_stage. The reference model treats the stage as a
// two-deep FIFO of already-killed bundles; the kill rule is phrased as "find
// the first live lane that ends the bundle, keep live lanes up to and
// including it". A narrow kill counter keeps saturation reachable.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ex_mem_lane_stage;

   localparam int LANES     = 2;
   localparam int PAYLOAD_W = 192;
   localparam int CNT_W     = 4;
   localparam int PW        = LANES * PAYLOAD_W;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   // ---------------- clock / reset / DUT ----------------
   logic                clk = 1'b0;
   logic                rstn = 1'b0;
   logic                flush = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [LANES-1:0]    in_lane_vld = '0;
   logic [LANES-1:0]    in_wreg_en = '0;
   logic [LANES-1:0]    in_serial = '0;
   logic [LANES-1:0]    in_taken = '0;
   logic [1:0]          in_irq = '0;
   logic [PW-1:0]       in_payload = '0;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic [LANES-1:0]    out_lane_vld;
   logic [LANES-1:0]    out_wreg_en;
   logic [1:0]          out_irq;
   logic [PW-1:0]       out_payload;
   logic [CNT_W-1:0]    kill_cnt;

   always #5 clk = ~clk;

   ex_mem_lane_stage #(
      .LANES(LANES), .PAYLOAD_W(PAYLOAD_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rstn(rstn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_lane_vld(in_lane_vld), .in_wreg_en(in_wreg_en),
      .in_serial(in_serial), .in_taken(in_taken), .in_irq(in_irq),
      .in_payload(in_payload),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_lane_vld(out_lane_vld), .out_wreg_en(out_wreg_en),
      .out_irq(out_irq), .out_payload(out_payload), .kill_cnt(kill_cnt)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [LANES-1:0] vld;
      logic [LANES-1:0] wreg;
      logic [1:0]       irq;
      logic [PW-1:0]    pay;
   } bundle_t;

   bundle_t exp_q[$];
   bit      m_ser = 1'b0;
   int      m_cnt = 0;
   bit      m_acc = 1'b0;
   bit      started = 1'b0;
   logic [7:0] obs_q[$];

   function automatic void model_capture(input bit blk, output bundle_t b,
                                         output int killed, output bit ser_out);
      int cutoff;
      cutoff = LANES;
      for (int j = 0; j < LANES; j++) begin
         if (cutoff == LANES && in_lane_vld[j] &&
             (in_serial[j] || in_taken[j] || (j == 0 && in_irq != 2'b00)))
            cutoff = j;
      end
      b.vld = '0;
      for (int i = 0; i < LANES; i++) begin
         if (!blk && in_lane_vld[i] && i <= cutoff) b.vld[i] = 1'b1;
      end
      killed  = $countones(in_lane_vld) - $countones(b.vld);
      b.wreg  = in_wreg_en & b.vld;
      b.irq   = b.vld[0] ? in_irq : 2'b00;
      b.pay   = in_payload;
      ser_out = |(b.vld & in_serial);
   endfunction

   always @(posedge clk) begin
      bundle_t b;
      int      k;
      bit      s;
      started = 1'b1;
      if (!rstn) begin
         exp_q.delete();
         m_ser = 1'b0;
         m_cnt = 0;
         m_acc = 1'b0;
      end else if (flush) begin
         exp_q.delete();
         m_ser = 1'b0;
         m_acc = 1'b0;
      end else begin
         m_acc = in_valid && (exp_q.size() < 2);
         if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
         if (m_acc) begin
            model_capture(m_ser, b, k, s);
            exp_q.push_back(b);
            m_ser = s;
            m_cnt = (m_cnt + k > CNT_MAX) ? CNT_MAX : m_cnt + k;
         end
      end
   end

   // Transfer monitor: tags of bundles handed to MEM, in order.
   always @(posedge clk) begin
      if (rstn && out_valid && out_ready) obs_q.push_back(out_payload[7:0]);
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      if (started) begin
         chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
         chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
         chk("kill_cnt", 64'(kill_cnt), 64'(m_cnt));
         if (exp_q.size() > 0) begin
            chk("out_lane_vld", 64'(out_lane_vld), 64'(exp_q[0].vld));
            chk("out_wreg_en", 64'(out_wreg_en), 64'(exp_q[0].wreg));
            chk("out_irq", 64'(out_irq), 64'(exp_q[0].irq));
            checks++;
            if (out_payload !== exp_q[0].pay) begin
               failures++;
               $display("FAIL out_payload actual=%h expected=%h", out_payload, exp_q[0].pay);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_in(input logic [LANES-1:0] vld, input logic [LANES-1:0] wreg,
                         input logic [LANES-1:0] ser, input logic [LANES-1:0] tak,
                         input logic [1:0] irq, input logic [7:0] tag);
      in_valid    = 1'b1;
      in_lane_vld = vld;
      in_wreg_en  = wreg;
      in_serial   = ser;
      in_taken    = tak;
      in_irq      = irq;
      in_payload  = {(PW/8){tag}};
   endtask

   task automatic send(input logic [LANES-1:0] vld, input logic [LANES-1:0] wreg,
                       input logic [LANES-1:0] ser, input logic [LANES-1:0] tak,
                       input logic [1:0] irq, input logic [7:0] tag);
      int n;
      n = 0;
      set_in(vld, wreg, ser, tak, irq, tag);
      do begin
         @(negedge clk);
         n++;
      end while (!m_acc && n < 20);
      chk("send_accepted", 64'(m_acc), 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      flush    = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      flush    = 1'b0;
      rstn     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstn     = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequences ----------------
   initial begin
      int n;
      do_reset();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_kill_cnt", 64'(kill_cnt), 64'd0);
      chk("rst_lane_vld", 64'(out_lane_vld), 64'd0);
      chk("rst_wreg_en", 64'(out_wreg_en), 64'd0);
      chk("rst_irq", 64'(out_irq), 64'd0);
      chk("rst_payload_zero", 64'(|out_payload), 64'd0);

      // Streaming
      out_ready = 1'b1;
      send(2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 8'hA1);
      chk("strm_a_valid", 64'(out_valid), 64'd1);
      chk("strm_a_lane", 64'(out_lane_vld), 64'h3);
      chk("strm_a_wreg", 64'(out_wreg_en), 64'h3);
      chk("strm_a_tag", 64'(out_payload[7:0]), 64'hA1);
      send(2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 8'hB2);
      chk("strm_b_tag", 64'(out_payload[7:0]), 64'hB2);
      chk("strm_b_wreg", 64'(out_wreg_en), 64'h2);
      chk("strm_ready", 64'(in_ready), 64'd1);
      idle();

      // In-bundle kill
      do_reset();
      out_ready = 1'b1;
      send(2'b11, 2'b11, 2'b00, 2'b01, 2'b00, 8'hC3);
      chk("kill_lane", 64'(out_lane_vld), 64'h1);
      chk("kill_wreg", 64'(out_wreg_en), 64'h1);
      chk("kill_cnt1", 64'(kill_cnt), 64'd1);
      send(2'b11, 2'b11, 2'b00, 2'b10, 2'b00, 8'hC4);
      chk("young_taken_lane", 64'(out_lane_vld), 64'h3);
      chk("young_taken_cnt", 64'(kill_cnt), 64'd1);
      idle();

      // Serialise
      do_reset();
      out_ready = 1'b1;
      send(2'b11, 2'b11, 2'b01, 2'b00, 2'b00, 8'hD1);
      chk("ser1_lane", 64'(out_lane_vld), 64'h1);
      chk("ser1_cnt", 64'(kill_cnt), 64'd1);
      send(2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 8'hD2);
      chk("ser2_valid", 64'(out_valid), 64'd1);
      chk("ser2_lane", 64'(out_lane_vld), 64'h0);
      chk("ser2_wreg", 64'(out_wreg_en), 64'h0);
      send(2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 8'hD3);
      chk("ser3_lane", 64'(out_lane_vld), 64'h3);
      chk("ser3_cnt", 64'(kill_cnt), 64'd3);
      idle();

      // Interrupt
      do_reset();
      out_ready = 1'b1;
      send(2'b11, 2'b11, 2'b00, 2'b00, 2'b01, 8'hE1);
      chk("irq1_irq", 64'(out_irq), 64'h1);
      chk("irq1_lane", 64'(out_lane_vld), 64'h1);
      send(2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 8'hE2);
      chk("irq2_irq", 64'(out_irq), 64'h0);
      chk("irq2_lane", 64'(out_lane_vld), 64'h2);
      chk("irq_cnt", 64'(kill_cnt), 64'd1);
      idle();

      // Backpressure
      do_reset();
      out_ready = 1'b0;
      obs_q.delete();
      send(2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 8'hF1);
      send(2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 8'hF2);
      chk("bp_ready_low", 64'(in_ready), 64'd0);
      chk("bp_head_a", 64'(out_payload[7:0]), 64'hF1);
      set_in(2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 8'hF3);
      @(negedge clk);
      chk("bp_c_held", 64'(m_acc), 64'd0);
      chk("bp_ready_still_low", 64'(in_ready), 64'd0);
      chk("bp_head_still_a", 64'(out_payload[7:0]), 64'hF1);
      out_ready = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!m_acc && n < 20);
      chk("bp_c_accepted", 64'(m_acc), 64'd1);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("bp_count", 64'(obs_q.size()), 64'd3);
      if (obs_q.size() == 3) begin
         chk("bp_order0", 64'(obs_q[0]), 64'hF1);
         chk("bp_order1", 64'(obs_q[1]), 64'hF2);
         chk("bp_order2", 64'(obs_q[2]), 64'hF3);
      end

      // Flush during stall
      do_reset();
      out_ready = 1'b0;
      send(2'b11, 2'b11, 2'b00, 2'b01, 2'b00, 8'h71);
      send(2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 8'h72);
      chk("fl_full", 64'(in_ready), 64'd0);
      chk("fl_cnt_before", 64'(kill_cnt), 64'd1);
      set_in(2'b11, 2'b11, 2'b00, 2'b01, 2'b00, 8'h73);
      flush = 1'b1;
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_out_valid", 64'(out_valid), 64'd0);
      chk("fl_in_ready", 64'(in_ready), 64'd1);
      chk("fl_cnt_kept", 64'(kill_cnt), 64'd1);
      @(negedge clk);
      chk("fl_stays_empty", 64'(out_valid), 64'd0);
      rstn = 1'b0;
      @(negedge clk);
      chk("fl_rst_cnt", 64'(kill_cnt), 64'd0);
      rstn = 1'b1;
      @(negedge clk);

      // Counter saturation
      out_ready = 1'b1;
      for (int i = 0; i < 14; i++) send(2'b11, 2'b11, 2'b00, 2'b01, 2'b00, 8'(i));
      chk("sat_14", 64'(kill_cnt), 64'd14);
      send(2'b11, 2'b11, 2'b00, 2'b01, 2'b00, 8'h5E);
      send(2'b11, 2'b11, 2'b00, 2'b01, 2'b00, 8'h5F);
      chk("sat_max", 64'(kill_cnt), 64'(CNT_MAX));
      idle();
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
